// File: rtl/dec_pkg.sv
// dec_pkg: shared mode/state encodings and width helper for the one-hot sequencer.
package dec_pkg;
    typedef enum logic [1:0] {
        DEC_MODE_LEVEL = 2'b00,
        DEC_MODE_PULSE = 2'b01,
        DEC_MODE_SCAN  = 2'b10,
        DEC_MODE_RSVD  = 2'b11
    } dec_mode_e;

    typedef enum logic [1:0] {
        DEC_ST_IDLE  = 2'b00,
        DEC_ST_HOLD  = 2'b01,
        DEC_ST_PULSE = 2'b10,
        DEC_ST_SCAN  = 2'b11
    } dec_state_e;

    function automatic int dec_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/dec_one_hot_seq_if.sv
// dec_one_hot_seq_if: request/status bundle between a requester and the one-hot sequencer.
interface dec_one_hot_seq_if #(
    parameter int PTR_BIT_WIDTH = 3,
    parameter int DEC_BIT_WIDTH = 8
);
    logic [PTR_BIT_WIDTH-1:0] ptr;
    logic                     d;
    logic [1:0]               mode;
    logic                     valid;
    logic                     ready;
    logic                     stop;
    logic [DEC_BIT_WIDTH-1:0] q;
    logic                     err;
    logic                     done;
    logic                     busy;

    modport master (output ptr, d, mode, valid, stop, input ready, q, err, done, busy);
    modport slave  (input ptr, d, mode, valid, stop, output ready, q, err, done, busy);
endinterface

// File: rtl/dec_dwell_timer.sv
// dec_dwell_timer: loadable down-counter; tc is high while the count sits at zero.
module dec_dwell_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end

    assign tc = cnt == '0;
endmodule

// File: rtl/dec_one_hot_seq.sv
// dec_one_hot_seq: registered handshaked one-hot decoder with LEVEL, PULSE and SCAN modes.
module dec_one_hot_seq
    import dec_pkg::*;
#(
    parameter int PTR_BIT_WIDTH = 3,
    parameter int DEC_BIT_WIDTH = 8,
    parameter int PULSE_LEN     = 4,
    parameter int SCAN_DWELL    = 2
) (
    input logic               clk,
    input logic               rst,
    dec_one_hot_seq_if.slave  bus
);
    localparam int PW  = PTR_BIT_WIDTH;
    localparam int PW1 = PTR_BIT_WIDTH + 1;
    localparam int CW  = dec_clog2(((PULSE_LEN > SCAN_DWELL) ? PULSE_LEN : SCAN_DWELL) + 1);
    localparam int SW  = dec_clog2(DEC_BIT_WIDTH + 1);

    if (DEC_BIT_WIDTH > 2 ** PTR_BIT_WIDTH || PULSE_LEN < 1 || SCAN_DWELL < 1) begin : g_bad_param
        $error("dec_one_hot_seq: illegal parameter combination");
    end

    dec_state_e          state, st_n;
    logic [PW-1:0]       pos, pos_n;
    logic [SW-1:0]       step, step_n;
    logic                d_r, d_n;
    logic                accept, bad, tc, last, adv, fin, load;
    logic [CW-1:0]       load_val;
    logic [DEC_BIT_WIDTH-1:0] q_n;

    assign accept = bus.valid && bus.ready;
    // Pointer compared one bit wider so DEC_BIT_WIDTH == 2**PTR_BIT_WIDTH never wraps
    assign bad    = {1'b0, bus.ptr} >= PW1'(DEC_BIT_WIDTH) || bus.mode == DEC_MODE_RSVD;
    assign last   = step == SW'(DEC_BIT_WIDTH - 1);
    assign adv    = state == DEC_ST_SCAN && tc && !last;
    assign fin    = tc && (state == DEC_ST_PULSE || (state == DEC_ST_SCAN && last));
    assign load   = (accept && !bad && (bus.mode == DEC_MODE_PULSE || bus.mode == DEC_MODE_SCAN))
                    || (adv && !bus.stop);
    assign load_val = (accept && bus.mode == DEC_MODE_PULSE) ? CW'(PULSE_LEN - 1) : CW'(SCAN_DWELL - 1);

    dec_dwell_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .en       (bus.busy),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= DEC_ST_IDLE;
        else state <= st_n;
    end

    always_comb begin
        st_n = bus.stop ? DEC_ST_IDLE
             : accept ? (bad ? DEC_ST_IDLE
                       : bus.mode == DEC_MODE_LEVEL ? DEC_ST_HOLD
                       : bus.mode == DEC_MODE_PULSE ? DEC_ST_PULSE : DEC_ST_SCAN)
             : fin ? DEC_ST_IDLE : state;
    end

    always_comb begin
        bus.ready = (state == DEC_ST_IDLE || state == DEC_ST_HOLD) && !bus.stop;
        bus.busy  = state == DEC_ST_PULSE || state == DEC_ST_SCAN;
    end

    // Q is derived only from the upcoming state and position, so it can never carry two bits
    always_comb begin
        pos_n  = accept ? bus.ptr : adv ? ((pos == PW'(DEC_BIT_WIDTH - 1)) ? '0 : pos + 1'b1) : pos;
        step_n = accept ? '0 : adv ? step + 1'b1 : step;
        d_n    = accept ? bus.d : d_r;
        q_n    = (st_n == DEC_ST_IDLE || !d_n) ? '0 : DEC_BIT_WIDTH'(1) << pos_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pos      <= '0;
            step     <= '0;
            d_r      <= 1'b0;
            bus.q    <= '0;
            bus.err  <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            pos      <= pos_n;
            step     <= step_n;
            d_r      <= d_n;
            bus.q    <= q_n;
            bus.err  <= accept && bad;
            bus.done <= fin && !bus.stop;
        end
    end
endmodule

// File: tb/tb_dec_one_hot_seq.sv
// tb_dec_one_hot_seq: directed checks of reset, LEVEL, PULSE, SCAN, rejects and STOP.
module tb_dec_one_hot_seq;
    import dec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;

    dec_one_hot_seq_if #(.PTR_BIT_WIDTH(3), .DEC_BIT_WIDTH(8)) bus8 ();
    dec_one_hot_seq_if #(.PTR_BIT_WIDTH(3), .DEC_BIT_WIDTH(5)) bus5 ();

    dec_one_hot_seq #(.PTR_BIT_WIDTH(3), .DEC_BIT_WIDTH(8), .PULSE_LEN(4), .SCAN_DWELL(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    dec_one_hot_seq #(.PTR_BIT_WIDTH(3), .DEC_BIT_WIDTH(5), .PULSE_LEN(4), .SCAN_DWELL(2)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] mode, input logic [2:0] ptr, input logic d);
        bus8.valid = 1'b1;
        bus8.mode  = mode;
        bus8.ptr   = ptr;
        bus8.d     = d;
    endtask

    initial begin
        bus8.valid = 1'b0; bus8.mode = 2'b00; bus8.ptr = '0; bus8.d = 1'b0; bus8.stop = 1'b0;
        bus5.valid = 1'b0; bus5.mode = 2'b00; bus5.ptr = '0; bus5.d = 1'b0; bus5.stop = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_q", 32'(bus8.q), 32'h0);
        chk("rst_err", 32'(bus8.err), 0);
        chk("rst_done", 32'(bus8.done), 0);
        chk("rst_busy", 32'(bus8.busy), 0);
        chk("rst_ready", 32'(bus8.ready), 1);

        // reset in the middle of a scan, sitting on position 5
        req(DEC_MODE_SCAN, 3'd3, 1'b1);
        tick();
        bus8.valid = 1'b0;
        chk("t1_first", 32'(bus8.q), 32'h08);
        repeat (4) tick();
        chk("t1_pos5", 32'(bus8.q), 32'h20);
        chk("t1_busy", 32'(bus8.busy), 1);
        chk("t1_ready", 32'(bus8.ready), 0);
        rst = 1'b1;
        tick();
        chk("t1_rst_q", 32'(bus8.q), 32'h0);
        chk("t1_rst_busy", 32'(bus8.busy), 0);
        chk("t1_rst_ready", 32'(bus8.ready), 1);
        chk("t1_rst_done", 32'(bus8.done), 0);
        rst = 1'b0;
        tick();
        chk("t1_after_done", 32'(bus8.done), 0);

        // LEVEL hold and direct replacement
        req(DEC_MODE_LEVEL, 3'd3, 1'b1);
        tick();
        bus8.valid = 1'b0;
        chk("t2_lvl3", 32'(bus8.q), 32'h08);
        chk("t2_busy", 32'(bus8.busy), 0);
        repeat (2) tick();
        chk("t2_held", 32'(bus8.q), 32'h08);
        chk("t2_ready", 32'(bus8.ready), 1);
        req(DEC_MODE_LEVEL, 3'd7, 1'b1);
        tick();
        chk("t2_lvl7", 32'(bus8.q), 32'h80);
        req(DEC_MODE_LEVEL, 3'd2, 1'b0);
        tick();
        bus8.valid = 1'b0;
        chk("t2_d0", 32'(bus8.q), 32'h0);

        // PULSE of exactly four cycles
        req(DEC_MODE_PULSE, 3'd0, 1'b1);
        tick();
        bus8.valid = 1'b0;
        chk("t3_q0", 32'(bus8.q), 32'h01);
        chk("t3_ready0", 32'(bus8.ready), 0);
        chk("t3_busy0", 32'(bus8.busy), 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk($sformatf("t3_q%0d", i), 32'(bus8.q), 32'h01);
            chk($sformatf("t3_ready%0d", i), 32'(bus8.ready), 0);
            chk($sformatf("t3_done%0d", i), 32'(bus8.done), 0);
        end
        tick();
        chk("t3_end_q", 32'(bus8.q), 32'h0);
        chk("t3_end_done", 32'(bus8.done), 1);
        chk("t3_end_busy", 32'(bus8.busy), 0);
        tick();
        chk("t3_done_1cyc", 32'(bus8.done), 0);

        // SCAN from 6 with wrap; a LEVEL request held during the scan must be ignored
        req(DEC_MODE_SCAN, 3'd6, 1'b1);
        tick();
        req(DEC_MODE_LEVEL, 3'd1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4_q%0d", i), 32'(bus8.q), 32'h1 << ((6 + i / 2) % 8));
            chk($sformatf("t4_ready%0d", i), 32'(bus8.ready), 0);
            chk($sformatf("t4_done%0d", i), 32'(bus8.done), 0);
            tick();
        end
        chk("t4_end_q", 32'(bus8.q), 32'h0);
        chk("t4_end_done", 32'(bus8.done), 1);
        bus8.valid = 1'b0;
        tick();
        chk("t4_idle_q", 32'(bus8.q), 32'h0);
        chk("t4_done_1cyc", 32'(bus8.done), 0);

        // rejects: out-of-range pointer on the 5-wide decoder, reserved mode on the 8-wide one
        bus5.valid = 1'b1; bus5.mode = DEC_MODE_LEVEL; bus5.ptr = 3'd4; bus5.d = 1'b1;
        tick();
        chk("t5_ptr4_q", 32'(bus5.q), 32'h10);
        chk("t5_ptr4_err", 32'(bus5.err), 0);
        bus5.ptr = 3'd5;
        tick();
        bus5.valid = 1'b0;
        chk("t5_ptr5_err", 32'(bus5.err), 1);
        chk("t5_ptr5_q", 32'(bus5.q), 32'h0);
        chk("t5_ptr5_done", 32'(bus5.done), 0);
        chk("t5_ptr5_busy", 32'(bus5.busy), 0);
        tick();
        chk("t5_ptr5_err_1cyc", 32'(bus5.err), 0);
        req(DEC_MODE_LEVEL, 3'd2, 1'b1);
        tick();
        chk("t5_pre_q", 32'(bus8.q), 32'h04);
        req(DEC_MODE_RSVD, 3'd1, 1'b1);
        tick();
        bus8.valid = 1'b0;
        chk("t5_rsvd_err", 32'(bus8.err), 1);
        chk("t5_rsvd_q", 32'(bus8.q), 32'h0);
        chk("t5_rsvd_done", 32'(bus8.done), 0);
        chk("t5_rsvd_ready", 32'(bus8.ready), 1);
        tick();
        chk("t5_rsvd_err_1cyc", 32'(bus8.err), 0);
        chk("t5_rsvd_idle_q", 32'(bus8.q), 32'h0);

        // STOP in the third PULSE cycle beats a simultaneous request
        req(DEC_MODE_PULSE, 3'd2, 1'b1);
        tick();
        bus8.valid = 1'b0;
        chk("t6_c1", 32'(bus8.q), 32'h04);
        tick();
        chk("t6_c2", 32'(bus8.q), 32'h04);
        tick();
        chk("t6_c3", 32'(bus8.q), 32'h04);
        bus8.stop = 1'b1;
        req(DEC_MODE_LEVEL, 3'd5, 1'b1);
        #1;
        chk("t6_ready_stop", 32'(bus8.ready), 0);
        tick();
        chk("t6_stop_q", 32'(bus8.q), 32'h0);
        chk("t6_stop_done", 32'(bus8.done), 0);
        chk("t6_stop_busy", 32'(bus8.busy), 0);
        bus8.stop = 1'b0;
        bus8.valid = 1'b0;
        tick();
        chk("t6_not_accepted", 32'(bus8.q), 32'h0);
        chk("t6_no_done", 32'(bus8.done), 0);
        chk("t6_ready_after", 32'(bus8.ready), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
